alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  EX-stage compute block of the 5-stage MIPS pipeline: ALU-op decode + 32-bit ALU + branch-target adder + HI/LO regs.
//  Decodes the 5-bit ALUOp from the controller together with the instruction funct/shamt/rs fields.
//  Produces the ALU result, zero and write-enable flags, and the branch target.
//  Holds the HI/LO multiply registers.
// PARAMETERS
//  none (width fixed at 32; operation codes live in alu_pkg)
// PORTS
//  Clk           in   1   clock; one clock, HI/LO update on rising edge
//  Reset         in   1   reset, asynchronous, active-low
//  ALUOp         in   5   class from controller: 0 R-type, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLT, 7 SLTU, 8 LUI, 9 SPECIAL2, 10 SPECIAL3
//  Funct         in   6   instr[5:0]
//  Shamt         in   5   instr[10:6]; shift amount, and the BSHFL selector for SPECIAL3
//  RsField       in   5   instr[25:21]; bit0 selects ROTR for funct 0x02
//  A             in   32  operand rs (already forwarded)
//  B             in   32  operand rt or extended immediate (already muxed)
//  PCPlus4       in   32  PC+4 of the instruction
//  Offset        in   32  sign-extended branch offset
//  Result        out  32  ALU result (combinational)
//  Zero          out  1   Result==0
//  WrEn          out  1   0 only when a MOVZ/MOVN condition fails, else 1
//  BranchTarget  out  32  PCPlus4 + (Offset<<2), modulo 2^32
//  HI, LO        out  32  HI/LO register contents
// BEHAVIOUR
//  - Decode, R-type funct: 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU;
//    00 SLL, 02 SRL (ROTR if RsField[0]), 03 SRA, 04 SLLV, 06 SRLV (ROTRV if Shamt[0]), 07 SRAV;
//    18 MULT, 19 MULTU, 10 MFHI, 11 MTHI, 12 MFLO, 13 MTLO, 0A MOVZ, 0B MOVN. Unknown funct -> ADD.
//  - Decode, SPECIAL2: funct 00 MADD, 04 MSUB, 02 MUL. Other funct -> ADD.
//  - Decode, SPECIAL3: funct 20 with Shamt 10 SEB, Shamt 18 SEH. Other combinations -> ADD.
//  - Decode, other ALUOp: undefined ALUOp -> ADD.
//  - Arithmetic: wraps, no overflow trap; SLT signed, SLTU unsigned, both giving 0/1.
//  - Shifts: fixed shifts use Shamt; variable shifts use A[4:0] as amount with B as the data; shift by 0 returns B.
//  - LUI: {B[15:0],16'h0}. SEB/SEH: sign-extend B[7:0]/B[15:0].
//  - MOVZ/MOVN: Result=A; WrEn = (B==0) for MOVZ, (B!=0) for MOVN.
//  - MUL: Result = low 32 bits of signed A*B; HI/LO untouched.
//  - MFHI/MFLO: Result = current register value. A write in the same cycle is not bypassed; the new value is visible next cycle.
//  - HI/LO writes, all on the Clk edge:
//    MULT -> {HI,LO} <= signed A*B; MULTU -> unsigned A*B;
//    MADD -> {HI,LO} <= {HI,LO} + signed A*B; MSUB -> {HI,LO} <= {HI,LO} - signed A*B (64-bit wrap);
//    MTHI -> HI <= A; MTLO -> LO <= A.
//  - HI/LO are written only by the ops above, once per cycle.
//  - Result for MULT/MULTU/MADD/MSUB/MTHI/MTLO is 0.
//  - Reset low: HI=LO=0 immediately, holding while low; combinational outputs still follow the inputs.
//  - Latency: all outputs combinational except HI/LO (1 cycle).
// CONFIGURATION
//  ALU_ROTATE_EN defined: ROTR/ROTRV as decoded above.
//  ALU_ROTATE_EN undefined: RsField[0]/Shamt[0] ignored; funct 02/06 are always logical SRL/SRLV.
// STRUCTURE
//  alu_pkg: ALUOp class codes, internal 5-bit ALU operation enum, funct/BSHFL constants.
//  Sub-module alu_op_decode: pure combinational map ALUOp/Funct/Shamt/RsField -> op enum + hilo_we.
//  Datapath, adder and HI/LO regs live in the top.
// TESTING
//  - ALUOp=0, Funct=20, A=7FFFFFFF, B=1 -> Result=80000000, Zero=0, WrEn=1; Funct=22, A=B=5 -> Result=0, Zero=1.
//  - Funct=2A, A=FFFFFFFF, B=1 -> Result 1; Funct=2B with same operands -> Result 0.
//  - Funct=03, Shamt=4, B=80000000 -> F8000000.
//  - Funct=02, RsField=1, Shamt=4, B=0000000F -> F0000000 with ALU_ROTATE_EN defined, 00000000 without.
//  - Funct=18, A=FFFFFFFE, B=3, clock -> HI=FFFFFFFF, LO=FFFFFFFA; then ALUOp=9/Funct=00, A=B=2, clock -> LO=FFFFFFFE; then Funct=10 -> Result=HI.
//  - Funct=0A, B=1 -> WrEn=0; PCPlus4=100, Offset=FFFFFFFF -> BranchTarget=FC.
//  - Reset pulsed low mid-run -> HI=LO=0 asynchronously.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU: controller class codes, internal op enum,
// funct/BSHFL constants and a rotate helper.
package alu_pkg;

  typedef enum logic [4:0] {
    CLS_RTYPE    = 5'd0,
    CLS_ADD      = 5'd1,
    CLS_SUB      = 5'd2,
    CLS_AND      = 5'd3,
    CLS_OR       = 5'd4,
    CLS_XOR      = 5'd5,
    CLS_SLT      = 5'd6,
    CLS_SLTU     = 5'd7,
    CLS_LUI      = 5'd8,
    CLS_SPECIAL2 = 5'd9,
    CLS_SPECIAL3 = 5'd10
  } aluop_cls_e;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_ROTR, OP_SLLV, OP_SRLV, OP_SRAV, OP_ROTRV,
    OP_MULT, OP_MULTU, OP_MADD, OP_MSUB, OP_MUL,
    OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_MOVZ, OP_MOVN,
    OP_LUI, OP_SEB, OP_SEH
  } alu_op_e;

  localparam logic [5:0] F_SLL   = 6'h00, F_SRL   = 6'h02, F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04, F_SRLV  = 6'h06, F_SRAV  = 6'h07;
  localparam logic [5:0] F_MOVZ  = 6'h0A, F_MOVN  = 6'h0B;
  localparam logic [5:0] F_MFHI  = 6'h10, F_MTHI  = 6'h11, F_MFLO  = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18, F_MULTU = 6'h19;
  localparam logic [5:0] F_ADD   = 6'h20, F_ADDU  = 6'h21, F_SUB   = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24, F_OR    = 6'h25, F_XOR   = 6'h26, F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A, F_SLTU  = 6'h2B;
  localparam logic [5:0] F2_MADD = 6'h00, F2_MUL  = 6'h02, F2_MSUB = 6'h04;
  localparam logic [5:0] F3_BSHFL = 6'h20;
  localparam logic [4:0] BSHFL_SEB = 5'h10, BSHFL_SEH = 5'h18;

  function automatic logic [31:0] rotr32(input logic [31:0] d, input logic [4:0] s);
    return (d >> s) | (d << (6'd32 - {1'b0, s}));
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result bundle between the pipeline controller (master) and the EX unit (slave).
interface alu_exec_unit_if;
  logic [4:0]  ALUOp;
  logic [5:0]  Funct;
  logic [4:0]  Shamt;
  logic [4:0]  RsField;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] PCPlus4;
  logic [31:0] Offset;
  logic [31:0] Result;
  logic        Zero;
  logic        WrEn;
  logic [31:0] BranchTarget;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output ALUOp, Funct, Shamt, RsField, A, B, PCPlus4, Offset,
    input  Result, Zero, WrEn, BranchTarget, HI, LO
  );
  modport slave (
    input  ALUOp, Funct, Shamt, RsField, A, B, PCPlus4, Offset,
    output Result, Zero, WrEn, BranchTarget, HI, LO
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/Funct/Shamt/RsField -> internal op decode.
// Define ALU_ROTATE_EN to decode ROTR/ROTRV; otherwise funct 02/06 are plain logical shifts.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [4:0] ALUOp,
  input  logic [5:0] Funct,
  input  logic [4:0] Shamt,
  input  logic [4:0] RsField,
  output alu_op_e    op,
  output logic       hilo_we
);

  logic rot_fix, rot_var;
  logic unused_rs;
  assign unused_rs = &{1'b0, RsField};

`ifdef ALU_ROTATE_EN
  assign rot_fix = RsField[0];
  assign rot_var = Shamt[0];
`else
  assign rot_fix = 1'b0;
  assign rot_var = 1'b0;
`endif

  always_comb begin
    op = OP_ADD;
    case (ALUOp)
      CLS_RTYPE: begin
        case (Funct)
          F_ADD, F_ADDU: op = OP_ADD;
          F_SUB, F_SUBU: op = OP_SUB;
          F_AND:         op = OP_AND;
          F_OR:          op = OP_OR;
          F_XOR:         op = OP_XOR;
          F_NOR:         op = OP_NOR;
          F_SLT:         op = OP_SLT;
          F_SLTU:        op = OP_SLTU;
          F_SLL:         op = OP_SLL;
          F_SRL:         op = rot_fix ? OP_ROTR : OP_SRL;
          F_SRA:         op = OP_SRA;
          F_SLLV:        op = OP_SLLV;
          F_SRLV:        op = rot_var ? OP_ROTRV : OP_SRLV;
          F_SRAV:        op = OP_SRAV;
          F_MULT:        op = OP_MULT;
          F_MULTU:       op = OP_MULTU;
          F_MFHI:        op = OP_MFHI;
          F_MTHI:        op = OP_MTHI;
          F_MFLO:        op = OP_MFLO;
          F_MTLO:        op = OP_MTLO;
          F_MOVZ:        op = OP_MOVZ;
          F_MOVN:        op = OP_MOVN;
          default:       op = OP_ADD;
        endcase
      end
      CLS_ADD:  op = OP_ADD;
      CLS_SUB:  op = OP_SUB;
      CLS_AND:  op = OP_AND;
      CLS_OR:   op = OP_OR;
      CLS_XOR:  op = OP_XOR;
      CLS_SLT:  op = OP_SLT;
      CLS_SLTU: op = OP_SLTU;
      CLS_LUI:  op = OP_LUI;
      CLS_SPECIAL2: begin
        case (Funct)
          F2_MADD: op = OP_MADD;
          F2_MSUB: op = OP_MSUB;
          F2_MUL:  op = OP_MUL;
          default: op = OP_ADD;
        endcase
      end
      CLS_SPECIAL3: begin
        if (Funct == F3_BSHFL && Shamt == BSHFL_SEB)      op = OP_SEB;
        else if (Funct == F3_BSHFL && Shamt == BSHFL_SEH) op = OP_SEH;
        else                                              op = OP_ADD;
      end
      default: op = OP_ADD;
    endcase
  end

  assign hilo_we = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
                   (op == OP_MSUB) || (op == OP_MTHI)  || (op == OP_MTLO);

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage compute block: 32-bit ALU, branch-target adder and HI/LO multiply registers.
// Rotate decode is enabled by defining ALU_ROTATE_EN (see alu_op_decode).
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  alu_exec_unit_if.slave   bus
);

  alu_op_e     op;
  logic        hilo_we;
  logic [31:0] hi_q, lo_q, hi_d, lo_d;
  logic [31:0] result;
  logic        wr_en;
  logic [63:0] prod_s, prod_u;
  logic        unused_off;

  alu_op_decode u_dec (
    .ALUOp   (bus.ALUOp),
    .Funct   (bus.Funct),
    .Shamt   (bus.Shamt),
    .RsField (bus.RsField),
    .op      (op),
    .hilo_we (hilo_we)
  );

  assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
  assign prod_u = {32'b0, bus.A} * {32'b0, bus.B};

  always_comb begin
    result = '0;
    wr_en  = 1'b1;
    case (op)
      OP_ADD:   result = bus.A + bus.B;
      OP_SUB:   result = bus.A - bus.B;
      OP_AND:   result = bus.A & bus.B;
      OP_OR:    result = bus.A | bus.B;
      OP_XOR:   result = bus.A ^ bus.B;
      OP_NOR:   result = ~(bus.A | bus.B);
      OP_SLT:   result = {31'b0, $signed(bus.A) < $signed(bus.B)};
      OP_SLTU:  result = {31'b0, bus.A < bus.B};
      OP_SLL:   result = bus.B << bus.Shamt;
      OP_SRL:   result = bus.B >> bus.Shamt;
      OP_SRA:   result = $signed(bus.B) >>> bus.Shamt;
      OP_ROTR:  result = rotr32(bus.B, bus.Shamt);
      OP_SLLV:  result = bus.B << bus.A[4:0];
      OP_SRLV:  result = bus.B >> bus.A[4:0];
      OP_SRAV:  result = $signed(bus.B) >>> bus.A[4:0];
      OP_ROTRV: result = rotr32(bus.B, bus.A[4:0]);
      OP_MUL:   result = prod_s[31:0];
      OP_MFHI:  result = hi_q;
      OP_MFLO:  result = lo_q;
      OP_MOVZ: begin
        result = bus.A;
        wr_en  = (bus.B == '0);
      end
      OP_MOVN: begin
        result = bus.A;
        wr_en  = (bus.B != '0);
      end
      OP_LUI:   result = {bus.B[15:0], 16'h0};
      OP_SEB:   result = {{24{bus.B[7]}}, bus.B[7:0]};
      OP_SEH:   result = {{16{bus.B[15]}}, bus.B[15:0]};
      default:  result = '0;
    endcase
  end

  // MADD/MSUB accumulate on the 64-bit {HI,LO} pair, wrapping mod 2^64.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hilo_we) begin
      case (op)
        OP_MULT:  {hi_d, lo_d} = prod_s;
        OP_MULTU: {hi_d, lo_d} = prod_u;
        OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
        OP_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
        OP_MTHI:  hi_d = bus.A;
        OP_MTLO:  lo_d = bus.A;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign unused_off       = &{1'b0, bus.Offset[31:30]};
  assign bus.Result       = result;
  assign bus.Zero         = (result == '0);
  assign bus.WrEn         = wr_en;
  assign bus.BranchTarget = bus.PCPlus4 + {bus.Offset[29:0], 2'b00};
  assign bus.HI           = hi_q;
  assign bus.LO           = lo_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit against an instruction-level reference model.
module tb_alu_exec_unit;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [31:0] m_hi, m_lo;

`ifdef ALU_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  alu_exec_unit_if bus ();

  alu_exec_unit dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_rotr(input logic [31:0] v, input int unsigned n);
    logic [31:0] r;
    r = v;
    for (int unsigned i = 0; i < n; i++) r = {r[0], r[31:1]};
    return r;
  endfunction

  // Reference model: instruction semantics computed directly from operands and HI/LO state.
  task automatic model(input logic [4:0] cls, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [4:0] rs, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic we,
                       output logic [31:0] nhi, output logic [31:0] nlo);
    longint          ps;
    longint unsigned pu, acc;
    ps  = longint'($signed(a)) * longint'($signed(b));
    pu  = longint'({32'b0, a}) * longint'({32'b0, b});
    acc = {m_hi, m_lo};
    res = a + b;
    we  = 1'b1;
    nhi = m_hi;
    nlo = m_lo;
    case (cls)
      5'd0: case (fn)
        6'h20, 6'h21: res = a + b;
        6'h22, 6'h23: res = a - b;
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h26: res = a ^ b;
        6'h27: res = ~(a | b);
        6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h2B: res = (a < b) ? 32'd1 : 32'd0;
        6'h00: res = b << sh;
        6'h02: res = (ROT && rs[0]) ? m_rotr(b, sh) : b >> sh;
        6'h03: res = $signed(b) >>> sh;
        6'h04: res = b << a[4:0];
        6'h06: res = (ROT && sh[0]) ? m_rotr(b, a[4:0]) : b >> a[4:0];
        6'h07: res = $signed(b) >>> a[4:0];
        6'h18: begin res = 0; {nhi, nlo} = ps; end
        6'h19: begin res = 0; {nhi, nlo} = pu; end
        6'h10: res = m_hi;
        6'h12: res = m_lo;
        6'h11: begin res = 0; nhi = a; end
        6'h13: begin res = 0; nlo = a; end
        6'h0A: begin res = a; we = (b == 0); end
        6'h0B: begin res = a; we = (b != 0); end
        default: res = a + b;
      endcase
      5'd1: res = a + b;
      5'd2: res = a - b;
      5'd3: res = a & b;
      5'd4: res = a | b;
      5'd5: res = a ^ b;
      5'd6: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd7: res = (a < b) ? 32'd1 : 32'd0;
      5'd8: res = b * 65536;
      5'd9: case (fn)
        6'h00: begin res = 0; {nhi, nlo} = acc + longint'(ps); end
        6'h04: begin res = 0; {nhi, nlo} = acc - longint'(ps); end
        6'h02: res = ps[31:0];
        default: res = a + b;
      endcase
      5'd10: begin
        if (fn == 6'h20 && sh == 5'h10)      res = $signed(b[7:0]);
        else if (fn == 6'h20 && sh == 5'h18) res = $signed(b[15:0]);
      end
      default: res = a + b;
    endcase
  endtask

  task automatic step(input logic [4:0] cls, input logic [5:0] fn, input logic [4:0] sh,
                      input logic [4:0] rs, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic [31:0] off);
    logic [31:0] er, nh, nl;
    logic        ew;
    bus.ALUOp = cls; bus.Funct = fn; bus.Shamt = sh; bus.RsField = rs;
    bus.A = a; bus.B = b; bus.PCPlus4 = pc; bus.Offset = off;
    #1;
    model(cls, fn, sh, rs, a, b, er, ew, nh, nl);
    check("Result", bus.Result, er);
    check("Zero", {31'b0, bus.Zero}, {31'b0, er == 0});
    check("WrEn", {31'b0, bus.WrEn}, {31'b0, ew});
    check("BranchTarget", bus.BranchTarget, pc + off * 4);
    @(posedge clk);
    #1;
    m_hi = nh;
    m_lo = nl;
    check("HI", bus.HI, m_hi);
    check("LO", bus.LO, m_lo);
  endtask

  logic [5:0] rfuncts [24] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                               6'h18, 6'h19, 6'h10, 6'h11, 6'h12, 6'h13, 6'h0A, 6'h0B};
  logic [5:0] s2functs [3] = '{6'h00, 6'h04, 6'h02};

  initial begin
    logic [4:0]  cls, sh;
    logic [5:0]  fn;
    logic [31:0] a, b;
    n_tests = 0;
    n_fail  = 0;
    m_hi = 0;
    m_lo = 0;
    rst_n = 1'b0;
    bus.ALUOp = 0; bus.Funct = 6'h20; bus.Shamt = 0; bus.RsField = 0;
    bus.A = 0; bus.B = 0; bus.PCPlus4 = 0; bus.Offset = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset HI", bus.HI, 32'h0);
    check("reset LO", bus.LO, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    step(0, 6'h20, 0, 0, 32'h7FFFFFFF, 32'h1, 0, 0);
    check("add overflow wrap", bus.Result, 32'h80000000);
    step(0, 6'h22, 0, 0, 32'h5, 32'h5, 0, 0);
    step(0, 6'h2A, 0, 0, 32'hFFFFFFFF, 32'h1, 0, 0);
    step(0, 6'h2B, 0, 0, 32'hFFFFFFFF, 32'h1, 0, 0);
    step(0, 6'h03, 5'd4, 0, 0, 32'h80000000, 0, 0);
    step(0, 6'h02, 5'd4, 5'd1, 0, 32'h0000000F, 0, 0);
    check("rotr/srl", bus.Result, ROT ? 32'hF0000000 : 32'h0);
    step(0, 6'h06, 5'd1, 0, 32'd4, 32'h0000000F, 0, 0);
    step(0, 6'h18, 0, 0, 32'hFFFFFFFE, 32'h3, 0, 0);
    check("mult HI", bus.HI, 32'hFFFFFFFF);
    check("mult LO", bus.LO, 32'hFFFFFFFA);
    step(9, 6'h00, 0, 0, 32'h2, 32'h2, 0, 0);
    check("madd LO", bus.LO, 32'hFFFFFFFE);
    step(0, 6'h10, 0, 0, 0, 0, 0, 0);
    check("mfhi", bus.Result, 32'hFFFFFFFF);
    step(0, 6'h0A, 0, 0, 32'h1234, 32'h1, 32'h100, 32'hFFFFFFFF);
    check("branch target", bus.BranchTarget, 32'hFC);
    step(10, 6'h20, 5'h10, 0, 0, 32'h00000080, 0, 0);
    step(10, 6'h20, 5'h18, 0, 0, 32'h00008000, 0, 0);
    step(8, 0, 0, 0, 0, 32'h0000ABCD, 0, 0);
    step(9, 6'h04, 0, 0, 32'hFFFFFFFF, 32'h7, 0, 0);
    step(0, 6'h3F, 0, 0, 32'h10, 32'h20, 0, 0);
    step(5'd20, 0, 0, 0, 32'h10, 32'h20, 0, 0);

    for (int i = 0; i < 400; i++) begin
      cls = 5'($urandom_range(0, 13));
      if (cls > 10) cls = 5'($urandom_range(11, 31));
      fn = 6'($urandom);
      sh = 5'($urandom);
      if (cls == 0 && $urandom_range(0, 9) != 0) fn = rfuncts[$urandom_range(0, 23)];
      if (cls == 9 && $urandom_range(0, 4) != 0) fn = s2functs[$urandom_range(0, 2)];
      if (cls == 10 && $urandom_range(0, 4) != 0) begin
        fn = 6'h20;
        sh = ($urandom_range(0, 1) != 0) ? 5'h10 : 5'h18;
      end
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 0;
      if ($urandom_range(0, 7) == 0) a = b;
      step(cls, fn, sh, 5'($urandom), a, b, $urandom, $urandom);
    end

    step(0, 6'h11, 0, 0, 32'h12345678, 0, 0, 0);
    step(0, 6'h13, 0, 0, 32'h9ABCDEF0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset HI", bus.HI, 32'h0);
    check("async reset LO", bus.LO, 32'h0);
    bus.ALUOp = 0; bus.Funct = 6'h11; bus.A = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    check("reset hold HI", bus.HI, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = 0;
    m_lo = 0;
    @(posedge clk);
    #1;
    m_hi = 32'hDEADBEEF;
    check("post-reset mthi", bus.HI, m_hi);
    step(0, 6'h12, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
